// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-parity link.
// Contents:
//   FRAME_BITS - serial bits per frame: start, A[3:0], par_A, B[3:0], par_B, stop
//   NIBBLE_W   - operand width
//   state_e    - receiver FSM state encoding
package alu_pkg;

  localparam int FRAME_BITS = 12;
  localparam int NIBBLE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA_A = 3'd2,
    ST_PAR_A  = 3'd3,
    ST_DATA_B = 3'd4,
    ST_PAR_B  = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/nibble_parity.sv
// Combinational XOR reduction of one operand nibble.
// The transmit side uses the same block, so both ends agree on the parity rule.
// Ports:
//   data_i [NIBBLE_W-1:0] - operand nibble
//   par_o                 - XOR of all data bits (even parity over data plus parity bit)
module nibble_parity
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] data_i,
  output logic                par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial receiver for the ALU operand-parity link.
// Deserialises {start, A[3:0], par_A, B[3:0], par_B, stop}, LSB first, idle high.
// It recomputes the parity of each operand and flags parity and framing errors.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx_in     - serial line (asynchronous to clk)
//   chk_en    - parity check enable; sampled in the cycle the stop bit is taken
//   a_out     - received operand A (held until the next frame)
//   b_out     - received operand B (held until the next frame)
//   valid     - one-cycle pulse per completed frame
//   err_a     - parity mismatch on A
//   err_b     - parity mismatch on B
//   frame_err - stop bit sampled low
//   busy      - FSM not in IDLE
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for rx_s low
// START   | confirming the start bit at half a bit period
// DATA_A  | shifting in A[3:0], one bit per bit period
// PAR_A   | capturing the parity bit for A
// DATA_B  | shifting in B[3:0]
// PAR_B   | capturing the parity bit for B
// STOP    | sampling the stop bit, then presenting results with valid
module parity_frame_rx
  import alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_in,
  input  logic                chk_en,
  output logic [NIBBLE_W-1:0] a_out,
  output logic [NIBBLE_W-1:0] b_out,
  output logic                valid,
  output logic                err_a,
  output logic                err_b,
  output logic                frame_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(NIBBLE_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NIBBLE_W - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NIBBLE_W-1:0]    a_sh_q;
  logic [NIBBLE_W-1:0]    b_sh_q;
  logic                   par_a_q;
  logic                   par_b_q;
  logic                   calc_par_a;
  logic                   calc_par_b;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign busy = (state_q != ST_IDLE);

  nibble_parity u_par_a (.data_i(a_sh_q), .par_o(calc_par_a));
  nibble_parity u_par_b (.data_i(b_sh_q), .par_o(calc_par_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser resets to the idle-line level so reset never fakes a start bit.
      sync_q    <= '1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      par_a_q   <= 1'b0;
      par_b_q   <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      valid     <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      valid  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA_A;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          // From here on every sample lands mid-bit, one full bit period apart.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            case (state_q)
              ST_DATA_A: begin
                a_sh_q[idx_q] <= rx_s;
                idx_q         <= idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_q <= ST_PAR_A;
              end
              ST_PAR_A: begin
                par_a_q <= rx_s;
                idx_q   <= '0;
                state_q <= ST_DATA_B;
              end
              ST_DATA_B: begin
                b_sh_q[idx_q] <= rx_s;
                idx_q         <= idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_q <= ST_PAR_B;
              end
              ST_PAR_B: begin
                par_b_q <= rx_s;
                state_q <= ST_STOP;
              end
              default: begin
                // Data and parity flags are presented even when the stop bit is bad.
                a_out     <= a_sh_q;
                b_out     <= b_sh_q;
                err_a     <= chk_en & (par_a_q != calc_par_a);
                err_b     <= chk_en & (par_b_q != calc_par_b);
                frame_err <= ~rx_s;
                valid     <= 1'b1;
                state_q   <= ST_IDLE;
              end
            endcase
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;
  import alu_pkg::*;

  localparam int CPB  = 4;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       chk_en = 1'b1;
  logic [3:0] a_out, b_out;
  logic       valid, err_a, err_b, frame_err, busy;

  parity_frame_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .chk_en(chk_en),
    .a_out(a_out), .b_out(b_out), .valid(valid), .err_a(err_a),
    .err_b(err_b), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Line history indexed by clock edge number. The receiver sees, at edge x,
  // the line value sampled SYNC edges earlier. A frame whose start is seen at
  // edge m is confirmed at m+CPB/2. Bit k (0..10 after start) is taken at
  // m+CPB/2+(k+1)*CPB. Results appear right after the stop-bit edge.
  int   n = 0;
  logic line_h [0:65535];
  logic chk_h  [0:65535];
  bit   m_pend = 0;
  int   m_start = 0;
  logic [3:0] exp_a = 0, exp_b = 0;
  logic exp_valid = 0, exp_ea = 0, exp_eb = 0, exp_fe = 0, exp_busy = 0;

  function automatic logic seen(input int x);
    if (x - SYNC < 1) return 1'b1;
    return line_h[x - SYNC];
  endfunction

  always @(posedge clk) begin
    logic [10:0] bits;
    n = n + 1;
    line_h[n] = rst ? 1'b1 : rx_in;
    chk_h[n]  = chk_en;
    if (rst) begin
      for (int j = 1; j < SYNC; j++) if (n - j >= 1) line_h[n - j] = 1'b1;
      m_pend = 0;
      exp_a = 0; exp_b = 0; exp_valid = 0; exp_ea = 0; exp_eb = 0; exp_fe = 0;
    end else begin
      exp_valid = 0;
      if (!m_pend) begin
        if (seen(n) == 1'b0) begin
          m_pend = 1; m_start = n;
        end
      end else if (n == m_start + CPB/2) begin
        if (seen(n) == 1'b1) m_pend = 0;
      end else if (n == m_start + CPB/2 + 11*CPB) begin
        for (int k = 0; k < 11; k++) bits[k] = seen(m_start + CPB/2 + (k+1)*CPB);
        exp_a  = bits[3:0];
        exp_b  = bits[8:5];
        exp_ea = chk_h[n] & (bits[4] != (bits[0] ^ bits[1] ^ bits[2] ^ bits[3]));
        exp_eb = chk_h[n] & (bits[9] != (bits[5] ^ bits[6] ^ bits[7] ^ bits[8]));
        exp_fe = ~bits[10];
        exp_valid = 1;
        m_pend = 0;
      end
    end
    exp_busy = m_pend;
  end

  // ---------------- compare process and event log ----------------
  typedef struct { int cyc; logic [3:0] a, b; logic ea, eb, fe; } ev_t;
  ev_t evq[$];
  int  busy_cnt = 0;

  always @(negedge clk) begin
    if (n > 0) begin
      chk("valid", valid, exp_valid);
      chk("busy", busy, exp_busy);
      chk("a_out", a_out, exp_a);
      chk("b_out", b_out, exp_b);
      chk("err_a", err_a, exp_ea);
      chk("err_b", err_b, exp_eb);
      chk("frame_err", frame_err, exp_fe);
      if (valid) begin
        ev_t e;
        e.cyc = n; e.a = a_out; e.b = b_out; e.ea = err_a; e.eb = err_b; e.fe = frame_err;
        evq.push_back(e);
      end
      if (busy) busy_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_chk = 0;

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) begin
      if (rand_chk) chk_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int cycles);
    rx_in = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic fa,
                            input logic fb, input logic stop, input int nbits,
                            output int fall);
    logic [FRAME_BITS-1:0] fr;
    fr = {stop, (^b) ^ fb, b, (^a) ^ fa, a, 1'b0};
    fall = n;
    for (int k = 0; k < nbits; k++) send_bit(fr[k]);
  endtask

  int f1, f2;
  ev_t e0, e1;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_a", a_out, 0);
    chk("rst_fe", frame_err, 0);

    // clean frame
    evq.delete();
    send_frame(4'b1011, 4'b0100, 0, 0, 1, FRAME_BITS, f1);
    idle(6);
    chk("clean_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      e0 = evq[0];
      chk("clean_latency", e0.cyc - f1, 49);
      chk("clean_a", e0.a, 4'b1011);
      chk("clean_b", e0.b, 4'b0100);
      chk("clean_errs", {e0.ea, e0.eb, e0.fe}, 0);
    end
    chk("model_a", exp_a, 4'b1011);
    chk("model_b", exp_b, 4'b0100);

    // parity_A flipped
    evq.delete();
    send_frame(4'b1011, 4'b0100, 1, 0, 1, FRAME_BITS, f1);
    idle(6);
    chk("pa_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("pa_err_a", evq[0].ea, 1);
      chk("pa_err_b", evq[0].eb, 0);
    end
    chk("model_pa_err", exp_ea, 1);

    // same with checking disabled
    evq.delete();
    chk_en = 1'b0;
    send_frame(4'b1011, 4'b0100, 1, 0, 1, FRAME_BITS, f1);
    idle(6);
    chk_en = 1'b1;
    chk("nochk_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("nochk_err_a", evq[0].ea, 0);
      chk("nochk_a", evq[0].a, 4'b1011);
    end

    // framing error
    evq.delete();
    send_frame(4'h0, 4'hF, 0, 0, 0, FRAME_BITS, f1);
    idle(16);
    chk("fe_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("fe_flag", evq[0].fe, 1);
      chk("fe_a", evq[0].a, 4'h0);
      chk("fe_b", evq[0].b, 4'hF);
      chk("fe_par", {evq[0].ea, evq[0].eb}, 0);
    end
    chk("model_fe", exp_fe, 1);

    // one-cycle glitch
    evq.delete();
    busy_cnt = 0;
    rx_in = 1'b0; @(posedge clk); #1;
    idle(20);
    chk("glitch_count", evq.size(), 0);
    chk("glitch_busy_cycles", busy_cnt, 2);
    chk("glitch_busy_end", busy, 0);

    // back-to-back frames
    evq.delete();
    send_frame(4'h3, 4'h5, 0, 0, 1, FRAME_BITS, f1);
    send_frame(4'hC, 4'hA, 0, 0, 1, FRAME_BITS, f2);
    idle(6);
    chk("b2b_count", evq.size(), 2);
    if (evq.size() >= 2) begin
      e0 = evq[0]; e1 = evq[1];
      chk("b2b_gap", e1.cyc - e0.cyc, 48);
      chk("b2b_ab0", {e0.a, e0.b}, 8'h35);
      chk("b2b_ab1", {e1.a, e1.b}, 8'hCA);
      chk("b2b_errs", {e0.ea, e0.eb, e0.fe, e1.ea, e1.eb, e1.fe}, 0);
    end

    // reset during DATA_B
    evq.delete();
    send_frame(4'h9, 4'h6, 0, 0, 1, 7, f1);
    chk("mid_busy", busy, 1);
    rst = 1'b1; rx_in = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {a_out, b_out, valid, err_a, err_b, frame_err}, 0);
    rst = 1'b0;
    idle(10);
    send_frame(4'h1, 4'h2, 0, 0, 1, FRAME_BITS, f1);
    idle(6);
    chk("post_rst_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("post_rst_ab", {evq[0].a, evq[0].b}, 8'h12);
      chk("post_rst_errs", {evq[0].ea, evq[0].eb, evq[0].fe}, 0);
    end

    // randomized traffic against the model
    rand_chk = 1;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        rx_in = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        idle($urandom_range(4, 8));
      end else begin
        send_frame(4'($urandom), 4'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 6) != 0), FRAME_BITS, f1);
        idle($urandom_range(0, 6));
      end
    end
    rand_chk = 0;
    idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
